// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO serializer.
// Holds the FSM state encoding, the frame-length function and the default idle level.
package piso_pkg;

    typedef enum logic {
        PISO_IDLE  = 1'b0,
        PISO_SHIFT = 1'b1
    } piso_state_e;

    localparam logic PISO_IDLE_LVL_DEF = 1'b0;

    // A frame has one extra slot when the parity bit is appended.
    function automatic int piso_flen(input int width, input bit parity_en);
        return parity_en ? width + 1 : width;
    endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Loadable down-counter with a terminal flag.
// It saturates at zero, so a decrement request at zero is ignored.
module piso_bit_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == '0);

endmodule

// File: rtl/piso_shift_serializer.sv
// Parallel-in/serial-out serializer with a valid/ready load and a per-word bit order.
// Define PISO_PARITY_EN to append an even-parity bit after each word.
module piso_shift_serializer
    import piso_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_LVL = PISO_IDLE_LVL_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             msb_first,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

`ifdef PISO_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int FLEN  = piso_flen(WIDTH, PARITY_EN);
    localparam int CNT_W = $clog2(FLEN);
    localparam int SR_W  = FLEN;

    piso_state_e      state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic             order_q, order_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             busy_q, busy_d;

    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic             in_shift;
    logic             adv;
    logic             fin;
    logic             ready_c;
    logic             accept;

`ifdef PISO_PARITY_EN
    // The parity bit sits at the tail end so it leaves after the last data bit.
    function automatic logic [SR_W-1:0] frame_word(input logic [WIDTH-1:0] d, input logic msb);
        return msb ? {d, ^d} : {^d, d};
    endfunction
`endif

    piso_bit_cnt #(
        .CNT_W(CNT_W)
    ) u_bit_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .load_val(CNT_W'(FLEN - 1)),
        .dec     (adv),
        .cnt     (cnt),
        .last    (cnt_last)
    );

    always_comb begin
        in_shift = (state_q == PISO_SHIFT);
        adv      = in_shift && shift_en && (cnt != '0);
        fin      = in_shift && shift_en && cnt_last;
        ready_c  = !in_shift || fin;
        accept   = load_valid && ready_c;

        state_d = state_q;
        sr_d    = sr_q;
        order_d = order_q;

        if (accept) begin
            state_d = PISO_SHIFT;
            order_d = msb_first;
`ifdef PISO_PARITY_EN
            sr_d = frame_word(load_data, msb_first);
`else
            sr_d = load_data;
`endif
        end else if (fin) begin
            state_d = PISO_IDLE;
        end else if (adv) begin
            sr_d = order_q ? (sr_q << 1) : (sr_q >> 1);
        end

        // Outputs are registered from next-state values so they line up with the state.
        sout_valid_d = (state_d == PISO_SHIFT);
        busy_d       = (state_d == PISO_SHIFT);
        sout_d       = IDLE_LVL;
        if (state_d == PISO_SHIFT) begin
            sout_d = order_d ? sr_d[SR_W-1] : sr_d[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PISO_IDLE;
            sr_q         <= '0;
            order_q      <= 1'b1;
            sout_q       <= IDLE_LVL;
            sout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            order_q      <= order_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign load_ready = ready_c;
    assign done       = fin;
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_piso_shift_serializer.sv
// Scoreboard bench for piso_shift_serializer: frames are expanded into expected bit queues.
// Honours PISO_PARITY_EN to match the DUT build.
module tb_piso_shift_serializer;

    localparam int   W    = 8;
    localparam logic IDLE = 1'b0;
`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct packed {
        logic b;
        logic last;
    } bit_t;

    typedef struct packed {
        logic [W-1:0] d;
        logic         msb;
    } word_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic [W-1:0] load_data = '0;
    logic         msb_first = 1'b1;
    logic         shift_en = 1'b0;
    logic         sout;
    logic         sout_valid;
    logic         busy;
    logic         done;

    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    done_seen = 0;
    bit    mdl_ready = 1'b1;
    bit_t  exp_q[$];
    word_t pend[$];

    piso_shift_serializer #(
        .WIDTH   (W),
        .IDLE_LVL(IDLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .msb_first (msb_first),
        .shift_en  (shift_en),
        .sout      (sout),
        .sout_valid(sout_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: a frame is the word's bits in the chosen order, then parity if enabled.
    task automatic push_frame(input word_t w);
        bit_t e;
        for (int i = 0; i < W; i++) begin
            e.b    = w.msb ? w.d[W-1-i] : w.d[i];
            e.last = (!PAR && (i == W - 1));
            exp_q.push_back(e);
        end
        if (PAR) begin
            e.b    = ^w.d;
            e.last = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: compare outputs on the falling edge and consume bits that advance.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (done) done_seen++;
                if (exp_q.size() > 0) begin
                    check("sout_valid", sout_valid, 1'b1);
                    check("busy", busy, 1'b1);
                    check("sout", sout, exp_q[0].b);
                    check("done", done, shift_en & exp_q[0].last);
                    if (shift_en) void'(exp_q.pop_front());
                end else begin
                    check("idle_sout_valid", sout_valid, 1'b0);
                    check("idle_busy", busy, 1'b0);
                    check("idle_sout", sout, IDLE);
                    check("idle_done", done, 1'b0);
                end
                mdl_ready = (exp_q.size() == 0);
                check("load_ready", load_ready, mdl_ready);
            end
        end
    end

    task automatic drive_cycle(input int mode);
        if (pend.size() > 0 && (mode != 2 || $urandom_range(3) != 0)) begin
            load_valid = 1'b1;
            load_data  = pend[0].d;
            msb_first  = pend[0].msb;
        end else begin
            load_valid = 1'b0;
            load_data  = W'($urandom);
            msb_first  = 1'($urandom);
        end
        case (mode)
            0:       shift_en = 1'b1;
            1:       shift_en = (cyc % 3 == 0);
            default: shift_en = 1'($urandom);
        endcase
        cyc++;
        @(posedge clk);
        if (load_valid && mdl_ready) begin
            push_frame(pend[0]);
            void'(pend.pop_front());
        end
        #1;
    endtask

    task automatic run_phase(input string name, input int mode, input int budget);
        int n = 0;
        cyc = 0;
        while ((pend.size() > 0 || exp_q.size() > 0) && n < budget) begin
            drive_cycle(mode);
            n++;
        end
        check({name, "_drained"}, pend.size() + exp_q.size(), 0);
        drive_cycle(mode);
        drive_cycle(mode);
    endtask

    task automatic add_word(input logic [W-1:0] d, input logic msb);
        word_t w;
        w.d   = d;
        w.msb = msb;
        pend.push_back(w);
    endtask

    initial begin
        int ds;
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sout", sout, IDLE);
        check("rst_sout_valid", sout_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_load_ready", load_ready, 1'b1);
        rst_n = 1'b1;

        add_word(8'hA5, 1'b1);
        run_phase("msb_a5", 0, 100);

        add_word(8'hA5, 1'b0);
        run_phase("lsb_a5", 0, 100);
        add_word(8'h01, 1'b0);
        run_phase("lsb_01", 0, 100);

        add_word(8'hF0, 1'b1);
        run_phase("stretch_f0", 1, 200);

        ds = done_seen;
        add_word(8'h81, 1'b1);
        add_word(8'h7E, 1'b1);
        run_phase("b2b", 0, 100);
        check("b2b_done_count", done_seen - ds, 2);

        // Abandon a frame mid-way with an asynchronous reset.
        add_word(8'hA5, 1'b1);
        n = 0;
        while (exp_q.size() == 0 && n < 10) begin
            drive_cycle(0);
            n++;
        end
        check("arst_frame_started", exp_q.size(), PAR ? W + 1 : W);
        repeat (3) drive_cycle(0);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        mdl_ready = 1'b1;
        #1;
        check("arst_sout_valid", sout_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_load_ready", load_ready, 1'b1);
        check("arst_sout", sout, IDLE);
        load_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        add_word(8'hC3, 1'b1);
        run_phase("after_rst_c3", 0, 100);

        add_word(8'h07, 1'b1);
        run_phase("par_07", 0, 100);
        add_word(8'h03, 1'b1);
        run_phase("par_03", 0, 100);

        for (int i = 0; i < 40; i++) add_word(W'($urandom), 1'($urandom));
        run_phase("random", 2, 4000);

        for (int i = 0; i < 10; i++) add_word(W'($urandom), 1'($urandom));
        run_phase("random_stretch", 1, 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
